button_io_array: RTL
====================

Name: button_io_array

Overview:
- Generalised front-panel input block: NUM_BTNS raw push-buttons, each synchronised and debounced per channel.
- Per channel, produces single-cycle press, release, long-press and auto-repeat strobes.
- Embeds an up/down level selector driven by two chosen channels, with wrap or saturate mode.
- Sits between board pins and the game FSM; replaces per-button debounce instances plus the ad-hoc level counter.

Parameters:
- NUM_BTNS, 4, number of button channels (>=2).
- DEBOUNCE_CNTR_WIDTH, 20, debounce counter width; an input change must persist 2^DEBOUNCE_CNTR_WIDTH cycles to be accepted.
- HOLD_CYCLES, 50000000, cycles of stable press before long_pulse.
- REPEAT_CYCLES, 10000000, cycles between repeat strobes after long press.
- REPEAT_EN, 1, 1 = auto-repeat enabled, 0 = repeat_pulse never asserts.
- NUM_LEVELS, 3, number of selectable levels (>=2).
- LEVEL_BITS, 2, width of level output; must satisfy 2^LEVEL_BITS >= NUM_LEVELS.
- UP_IDX, 0, channel that increments level.
- DOWN_IDX, 1, channel that decrements level (must differ from UP_IDX).
- WRAP_MODE, 1, 1 = wrap at ends, 0 = saturate.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  NUM_BTNS  raw asynchronous button inputs, active-high.
- btn_level  output  NUM_BTNS  debounced stable level per channel.
- press_pulse  output  NUM_BTNS  one-cycle strobe on accepted 0->1.
- release_pulse  output  NUM_BTNS  one-cycle strobe on accepted 1->0.
- long_pulse  output  NUM_BTNS  one-cycle strobe when hold reaches HOLD_CYCLES.
- repeat_pulse  output  NUM_BTNS  periodic strobe while held past long press.
- level  output  LEVEL_BITS  current selected level, 0..NUM_LEVELS-1.
- level_wrap  output  1  one-cycle strobe when level wraps (WRAP_MODE=1 only).

Behaviour:
- Reset: clock clk; reset rst_n is asynchronous, active-low.
- Reset state: all registers 0, including synchronisers. All outputs 0 and level = 0.
- A button held through reset is reported as a fresh press once debounced after reset release.
- Synchroniser: two-flop, per channel.
- Debounce, per channel (counter dcnt, stable bit):
  - If sync != stable, dcnt increments.
  - When dcnt == 2^W-1 and the mismatch persists, stable <= sync and dcnt <= 0.
  - If sync == stable at any cycle, dcnt <= 0; glitches shorter than 2^W cycles are rejected.
  - btn_level = stable.
- Edge strobes are registered. press_pulse is high in the cycle after stable rises; release_pulse in the cycle after stable falls. Each lasts exactly 1 cycle.
- Hold counter, per channel (width $clog2(HOLD_CYCLES+1)):
  - Cleared while stable = 0.
  - Increments while stable = 1, saturating at HOLD_CYCLES.
  - long_pulse fires once, in the cycle the counter first reaches HOLD_CYCLES.
- Repeat counter, per channel, active only when REPEAT_EN = 1 and hold is saturated:
  - repeat_pulse fires every REPEAT_CYCLES cycles; the first fires REPEAT_CYCLES cycles after long_pulse.
  - Release clears hold and repeat counters immediately; no strobe fires in the release cycle.
- Level selector:
  - up = press_pulse[UP_IDX] | repeat_pulse[UP_IDX]; down = press_pulse[DOWN_IDX] | repeat_pulse[DOWN_IDX].
  - up only: level+1. At NUM_LEVELS-1, go to 0 with level_wrap = 1 (wrap mode), or hold (saturate mode).
  - down only: level-1. At 0, go to NUM_LEVELS-1 with level_wrap = 1 (wrap mode), or hold (saturate mode).
  - up and down in the same cycle: no change, level_wrap = 0.
  - level and level_wrap update on the clock edge following the strobe.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.

Test Plan:
- Use DEBOUNCE_CNTR_WIDTH=3, HOLD_CYCLES=20, REPEAT_CYCLES=5, NUM_LEVELS=3 for all scenarios.
- Reset and glitch rejection: hold btn_raw[2]=1 for 5 cycles then 0 -> no press_pulse, btn_level[2] stays 0. Hold for 12 cycles -> exactly one press_pulse[2], 11 cycles after the raw rise. Release -> one release_pulse[2].
- Long press and repeat: hold btn_raw[0] 60 cycles -> one press_pulse, long_pulse 20 cycles after btn_level rises, then repeat_pulse every 5 cycles. On release, repeat stops and level advances once per press/repeat strobe.
- Wrap mode: from level 2, tap UP -> level 0 with a level_wrap strobe. From 0, tap DOWN -> level 2 with a level_wrap strobe.
- Saturate (WRAP_MODE=0): from level 2, tap UP 3 times -> level stays 2, level_wrap never asserts. From 0, tap DOWN -> stays 0.
- Simultaneous: press UP and DOWN in the same cycle -> both press_pulses assert, level unchanged. Press channels 2 and 3 together -> both strobes in the same cycle.
- Reset mid-hold: assert rst_n=0 during a hold on channel 0 with raw still 1 -> all outputs 0 immediately. After reset release -> new press_pulse after debounce, level 0 then increments to 1.

Source files
------------

// File: rtl/button_io_array.sv
// button_io_array
//   Front-panel input block. Each raw push-button is synchronised, debounced
//   and turned into single-cycle press / release / long-press / auto-repeat
//   strobes. Two channels additionally drive an up/down level selector that
//   either wraps or saturates at its ends.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   btn_raw        raw asynchronous buttons, active-high
//   btn_level      debounced stable level per channel
//   press_pulse    one-cycle strobe on accepted 0->1
//   release_pulse  one-cycle strobe on accepted 1->0
//   long_pulse     one-cycle strobe when a hold reaches HOLD_CYCLES
//   repeat_pulse   strobe every REPEAT_CYCLES while held past long press
//   level          selected level, 0..NUM_LEVELS-1
//   level_wrap     one-cycle strobe when level wraps (wrap mode only)
module button_io_array #(
    parameter int unsigned NUM_BTNS            = 4,
    parameter int unsigned DEBOUNCE_CNTR_WIDTH = 20,
    parameter int unsigned HOLD_CYCLES         = 50000000,
    parameter int unsigned REPEAT_CYCLES       = 10000000,
    parameter bit          REPEAT_EN           = 1'b1,
    parameter int unsigned NUM_LEVELS          = 3,
    parameter int unsigned LEVEL_BITS          = 2,
    parameter int unsigned UP_IDX              = 0,
    parameter int unsigned DOWN_IDX            = 1,
    parameter bit          WRAP_MODE           = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_BTNS-1:0]   btn_raw,
    output logic [NUM_BTNS-1:0]   btn_level,
    output logic [NUM_BTNS-1:0]   press_pulse,
    output logic [NUM_BTNS-1:0]   release_pulse,
    output logic [NUM_BTNS-1:0]   long_pulse,
    output logic [NUM_BTNS-1:0]   repeat_pulse,
    output logic [LEVEL_BITS-1:0] level,
    output logic                  level_wrap
);

    localparam int unsigned DW     = DEBOUNCE_CNTR_WIDTH;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DW-1:0]         DCNT_MAX  = '1;
    localparam logic [DW-1:0]         DCNT_ONE  = DW'(1);
    localparam logic [HOLD_W-1:0]     HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]     HOLD_PRE  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]     HOLD_ONE  = HOLD_W'(1);
    localparam logic [REP_W-1:0]      REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0]      REP_ONE   = REP_W'(1);
    localparam logic [LEVEL_BITS-1:0] LVL_MAX   = LEVEL_BITS'(NUM_LEVELS - 1);
    localparam logic [LEVEL_BITS-1:0] LVL_ONE   = LEVEL_BITS'(1);

    logic [NUM_BTNS-1:0]             sync0;
    logic [NUM_BTNS-1:0]             sync1;
    logic [NUM_BTNS-1:0]             stable;
    logic [NUM_BTNS-1:0]             stable_d;
    logic [NUM_BTNS-1:0]             stable_nxt;
    logic [NUM_BTNS-1:0][DW-1:0]     dcnt;
    logic [NUM_BTNS-1:0][DW-1:0]     dcnt_nxt;
    logic [NUM_BTNS-1:0][HOLD_W-1:0] hold_cnt;
    logic [NUM_BTNS-1:0][REP_W-1:0]  rep_cnt;

    logic up_evt;
    logic down_evt;

    assign btn_level = stable;

    // Debounce: a mismatch must survive 2^DW consecutive cycles; any cycle
    // of agreement restarts the count.
    always_comb begin
        stable_nxt = stable;
        dcnt_nxt   = '0;
        for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            if (sync1[i] != stable[i]) begin
                if (dcnt[i] == DCNT_MAX) begin
                    stable_nxt[i] = sync1[i];
                end else begin
                    dcnt_nxt[i] = dcnt[i] + DCNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0         <= '0;
            sync1         <= '0;
            stable        <= '0;
            stable_d      <= '0;
            dcnt          <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            sync0         <= btn_raw;
            sync1         <= sync0;
            stable        <= stable_nxt;
            stable_d      <= stable;
            dcnt          <= dcnt_nxt;
            press_pulse   <= stable & ~stable_d;
            release_pulse <= ~stable & stable_d;
        end
    end

    // Hold/repeat run only while the channel is held now and stays held on
    // this edge; looking at stable_nxt clears both counters on the release
    // edge itself so no long/repeat strobe can coincide with the release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            long_pulse   <= '0;
            repeat_pulse <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_BTNS; i++) begin
                if (!stable[i] || !stable_nxt[i]) begin
                    hold_cnt[i]     <= '0;
                    rep_cnt[i]      <= '0;
                    long_pulse[i]   <= 1'b0;
                    repeat_pulse[i] <= 1'b0;
                end else begin
                    long_pulse[i]   <= (hold_cnt[i] == HOLD_PRE);
                    repeat_pulse[i] <= 1'b0;
                    if (hold_cnt[i] != HOLD_MAX) begin
                        hold_cnt[i] <= hold_cnt[i] + HOLD_ONE;
                    end else if (REPEAT_EN) begin
                        if (rep_cnt[i] == REP_LAST) begin
                            rep_cnt[i]      <= '0;
                            repeat_pulse[i] <= 1'b1;
                        end else begin
                            rep_cnt[i] <= rep_cnt[i] + REP_ONE;
                        end
                    end
                end
            end
        end
    end

    assign up_evt   = press_pulse[UP_IDX]   | repeat_pulse[UP_IDX];
    assign down_evt = press_pulse[DOWN_IDX] | repeat_pulse[DOWN_IDX];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level      <= '0;
            level_wrap <= 1'b0;
        end else begin
            level_wrap <= 1'b0;
            if (up_evt && !down_evt) begin
                if (level == LVL_MAX) begin
                    if (WRAP_MODE) begin
                        level      <= '0;
                        level_wrap <= 1'b1;
                    end
                end else begin
                    level <= level + LVL_ONE;
                end
            end else if (down_evt && !up_evt) begin
                if (level == '0) begin
                    if (WRAP_MODE) begin
                        level      <= LVL_MAX;
                        level_wrap <= 1'b1;
                    end
                end else begin
                    level <= level - LVL_ONE;
                end
            end
        end
    end

endmodule
